// File: rtl/instr_sequencer_pkg.sv
// Shared opcode/state types and instruction-word field layout for the sequencer.
// Word layout, MSB first: [op 3 | rd 3 | ra 3 | rb 3 | imm N].
package seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_LDI  = 3'b101,
      OP_JMP  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WRITE, S_DONE
   } state_t;

   // Register-field offsets are measured from the top of the immediate.
   localparam int RB_OFS  = 0;
   localparam int RA_OFS  = 3;
   localparam int RD_OFS  = 6;
   localparam int OP_OFS  = 9;
   localparam int IMM_LSB = 0;

   function automatic int iw(input int n);
      return 12 + n;
   endfunction

   function automatic int op_msb(input int n);
      return OP_OFS + 2 + n;
   endfunction

   function automatic int rd_lsb(input int n);
      return RD_OFS + n;
   endfunction

   function automatic int ra_lsb(input int n);
      return RA_OFS + n;
   endfunction

   function automatic int rb_lsb(input int n);
      return RB_OFS + n;
   endfunction

   function automatic logic writes_rd(input opcode_t op);
      return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI});
   endfunction

endpackage

// File: rtl/instr_sequencer_pc_counter.sv
// Program counter: PW-bit register with clear > load > increment priority.
module pc_counter #(
   parameter int PW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          load,
   input  logic          inc,
   input  logic [PW-1:0] din,
   output logic [PW-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (inc) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Handshaked multi-cycle sequencer: fetch, decode, execute and write back
// instructions from program memory until HALT, then pulse done.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = 3,
   parameter int PW = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [PW-1:0]    pc,
   input  logic [iw(N)-1:0] instr,
   output logic [AW-1:0]    a0,
   output logic [AW-1:0]    a1,
   input  logic [N-1:0]     q0,
   input  logic [N-1:0]     q1,
   output logic [2:0]       alu_op,
   input  logic [N-1:0]     alu_y,
   output logic [AW-1:0]    aw,
   output logic [N-1:0]     wd,
   output logic             we
);

   state_t            state;
   logic [iw(N)-1:0]  ir;
   logic [N-1:0]      result;
   opcode_t           ir_op;
   logic              pc_clr;
   logic              pc_load;
   logic              pc_inc;

   assign ir_op = opcode_t'(ir[op_msb(N) -: 3]);

   // Read addresses come straight from ir, so they change only when a new
   // word is latched and hold their last value everywhere else.
   assign a0 = ir[ra_lsb(N) +: AW];
   assign a1 = ir[rb_lsb(N) +: AW];
   assign wd = result;

   // The regfile read data is consumed by the external ALU, not here.
   logic unused_q;
   assign unused_q = ^{q0, q1};

   always_comb begin
      pc_clr  = (state == S_IDLE) && start;
      pc_load = (state == S_DECODE) && (ir_op == OP_JMP);
      pc_inc  = (state == S_WRITE) || ((state == S_DECODE) && (ir_op == OP_NOP));
   end

   pc_counter #(.PW(PW)) u_pc (
      .clk   (clk),
      .reset (reset),
      .clr   (pc_clr),
      .load  (pc_load),
      .inc   (pc_inc),
      .din   (ir[IMM_LSB +: PW]),
      .q     (pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         ir     <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         we     <= 1'b0;
         aw     <= '0;
         alu_op <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FETCH;
                  busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               ir     <= instr;
               alu_op <= instr[op_msb(N) -: 3];
               state  <= S_DECODE;
            end
            S_DECODE: begin
               if (writes_rd(ir_op)) begin
                  state <= S_EXEC;
               end else if (ir_op == OP_HALT) begin
                  alu_op <= '0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  alu_op <= '0;
                  state  <= S_FETCH;
               end
            end
            S_EXEC: begin
               // alu_y has had the whole DECODE+EXEC window to settle.
               result <= (ir_op == OP_LDI) ? ir[IMM_LSB +: N] : alu_y;
               aw     <= ir[rd_lsb(N) +: AW];
               we     <= 1'b1;
               alu_op <= '0;
               state  <= S_WRITE;
            end
            S_WRITE: begin
               we    <= 1'b0;
               state <= S_FETCH;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench: an instruction-level interpreter predicts the
// per-cycle output trace, and a negedge monitor pops and compares it.
module tb_instr_sequencer;
   localparam int N  = 32;
   localparam int AW = 3;
   localparam int PW = 3;
   localparam int IW = 12 + N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, we;
   logic [PW-1:0] pc;
   logic [IW-1:0] instr;
   logic [AW-1:0] a0, a1, aw;
   logic [N-1:0]  q0, q1, alu_y, wd;
   logic [2:0]    alu_op;

   logic [IW-1:0] prog [8];
   logic [N-1:0]  rf   [8] = '{default: '0};
   logic [N-1:0]  mreg [8] = '{default: '0};

   int cyc = 0;
   int t0 = 0;
   int checks = 0;
   int errors = 0;
   bit strict = 1'b1;

   typedef struct {
      logic [2:0]  pc;
      logic [2:0]  op;
      logic        busy, we, done, chk_a;
      logic [2:0]  aw, a0, a1;
      logic [31:0] wd;
   } exp_t;

   exp_t trace_q[$];

   always #5 clk = ~clk;

   instr_sequencer #(.N(N), .AW(AW), .PW(PW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .pc(pc), .instr(instr), .a0(a0), .a1(a1), .q0(q0), .q1(q1),
      .alu_op(alu_op), .alu_y(alu_y), .aw(aw), .wd(wd), .we(we)
   );

   // Environment: program ROM, regfile and ALU around the sequencer.
   assign instr = prog[pc];
   assign q0 = rf[a0];
   assign q1 = rf[a1];
   always_comb begin
      alu_y = '0;
      case (alu_op)
         3'd1: alu_y = q0 + q1;
         3'd2: alu_y = q0 - q1;
         3'd3: alu_y = q0 & q1;
         3'd4: alu_y = q0 | q1;
         default: alu_y = '0;
      endcase
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (we) rf[aw] <= wd;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [IW-1:0] mkw(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [2:0] rb,
                                         input logic [31:0] imm);
      return {op, rd, ra, rb, imm};
   endfunction

   function automatic exp_t mk(input logic [2:0] p, input logic [2:0] op, input logic b,
                               input logic w, input logic d, input logic ca,
                               input logic [2:0] wa, input logic [2:0] ra,
                               input logic [2:0] rb, input logic [31:0] data);
      exp_t e;
      e.pc = p; e.op = op; e.busy = b; e.we = w; e.done = d; e.chk_a = ca;
      e.aw = wa; e.a0 = ra; e.a1 = rb; e.wd = data;
      return e;
   endfunction

   // Instruction-level interpreter. Returns the cycle (1 = first FETCH) in
   // which done is expected, or -1 if the program does not halt in budget.
   function automatic int model_run(input int abort_rel, input bit use_ovr,
                                    input logic [IW-1:0] ovr, input bit commit);
      logic [N-1:0]  lr [8];
      exp_t          lq[$];
      logic [IW-1:0] w;
      logic [2:0]    p, op, rd, ra, rb;
      logic [N-1:0]  imm, res;
      int            rel;
      p = '0;
      rel = 1;
      for (int i = 0; i < 8; i++) lr[i] = mreg[i];
      for (int s = 0; s < 60; s++) begin
         w = (use_ovr && s == 0) ? ovr : prog[p];
         {op, rd, ra, rb, imm} = w;
         lq.push_back(mk(p, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
         lq.push_back(mk(p, op, 1, 0, 0, 1, 0, ra, rb, 0));
         if (op >= 3'd1 && op <= 3'd5) begin
            case (op)
               3'd1: res = lr[ra] + lr[rb];
               3'd2: res = lr[ra] - lr[rb];
               3'd3: res = lr[ra] & lr[rb];
               3'd4: res = lr[ra] | lr[rb];
               default: res = imm;
            endcase
            lq.push_back(mk(p, op, 1, 0, 0, 1, 0, ra, rb, 0));
            lq.push_back(mk(p, 3'd0, 1, 1, 0, 0, rd, 0, 0, res));
            if (abort_rel == 0 || rel + 3 < abort_rel) lr[rd] = res;
            rel += 4;
            p = p + 3'd1;
         end else if (op == 3'd0) begin
            rel += 2;
            p = p + 3'd1;
         end else if (op == 3'd6) begin
            rel += 2;
            p = imm[2:0];
         end else begin
            lq.push_back(mk(p, 3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
            lq.push_back(mk(p, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
            if (commit) begin
               if (abort_rel > 0)
                  while (lq.size() > abort_rel - 1) void'(lq.pop_back());
               foreach (lq[i]) trace_q.push_back(lq[i]);
               for (int i = 0; i < 8; i++) mreg[i] = lr[i];
            end
            return rel + 2;
         end
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      if (trace_q.size() > 0 && cyc >= t0) begin
         exp_t e;
         e = trace_q.pop_front();
         chk("pc", pc, e.pc);
         chk("alu_op", alu_op, e.op);
         chk("busy", busy, e.busy);
         chk("we", we, e.we);
         chk("done", done, e.done);
         if (e.we) begin
            chk("aw", aw, e.aw);
            chk("wd", wd, e.wd);
         end
         if (e.chk_a) begin
            chk("a0", a0, e.a0);
            chk("a1", a1, e.a1);
         end
      end else if (strict) begin
         chk("idle_quiet", {busy, we, done}, 3'b000);
      end
   end

   task automatic fill_halt();
      for (int i = 0; i < 8; i++) prog[i] = mkw(3'd7, 0, 0, 0, 0);
   endtask

   // Caller is positioned #1 after a rising edge.
   task automatic run_prog(input string nm, input bit noise, input bit swap,
                           input logic [IW-1:0] first_word);
      int ncyc;
      int rel;
      logic [IW-1:0] keep;
      ncyc = model_run(0, swap, first_word, 1'b1);
      keep = prog[0];
      if (swap) prog[0] = first_word;
      t0 = cyc + 1;
      start = 1'b1;
      @(posedge clk); #1;
      rel = 1;
      while (!done && rel < 400) begin
         if (swap && rel == 2) prog[0] = keep;
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         rel++;
      end
      start = 1'b0;
      chk({nm, "_done_seen"}, done, 1'b1);
      chk({nm, "_done_cycle"}, rel, ncyc);
      repeat (3) begin @(posedge clk); #1; end
      chk({nm, "_drain"}, trace_q.size(), 0);
      $display("run %s: done at cycle %0d (model %0d), errors so far %0d", nm, rel, ncyc, errors);
   endtask

   initial begin
      int n;
      int rel;
      fill_halt();
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", we, 0);
      chk("rst_pc", pc, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_a0", a0, 0);
      chk("rst_a1", a1, 0);
      chk("rst_aw", aw, 0);
      chk("rst_wd", wd, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // LDI/LDI/ADD/HALT
      fill_halt();
      prog[0] = mkw(3'd5, 3'd1, 0, 0, 32'd5);
      prog[1] = mkw(3'd5, 3'd2, 0, 0, 32'd7);
      prog[2] = mkw(3'd1, 3'd3, 3'd1, 3'd2, 32'd0);
      run_prog("ldi_add", 1'b0, 1'b0, '0);
      chk("r3_sum", rf[3], 32'd12);

      // JMP/NOP/HALT
      fill_halt();
      prog[0] = mkw(3'd6, 0, 0, 0, 32'd3);
      prog[3] = mkw(3'd0, 0, 0, 0, 32'd0);
      run_prog("jmp_nop", 1'b0, 1'b0, '0);

      // pc wrap 7 -> 0: first pass word 0 is JMP 7, then it becomes HALT
      fill_halt();
      prog[7] = mkw(3'd0, 0, 0, 0, 32'd0);
      run_prog("wrap", 1'b0, 1'b1, mkw(3'd6, 0, 0, 0, 32'd7));

      // SUB/AND/OR
      fill_halt();
      prog[0] = mkw(3'd5, 3'd1, 0, 0, 32'hF0);
      prog[1] = mkw(3'd5, 3'd2, 0, 0, 32'h3C);
      prog[2] = mkw(3'd2, 3'd4, 3'd1, 3'd2, 32'd0);
      prog[3] = mkw(3'd3, 3'd5, 3'd1, 3'd2, 32'd0);
      prog[4] = mkw(3'd4, 3'd6, 3'd1, 3'd2, 32'd0);
      run_prog("sub_and_or", 1'b1, 1'b0, '0);
      chk("r4_sub", rf[4], 32'hB4);
      chk("r5_and", rf[5], 32'h30);
      chk("r6_or", rf[6], 32'hFC);

      // start held high through DONE: immediate restart after one IDLE cycle
      fill_halt();
      prog[0] = mkw(3'd5, 3'd7, 0, 0, $urandom);
      n = model_run(0, 1'b0, '0, 1'b1);
      n = model_run(0, 1'b0, '0, 1'b1);
      t0 = cyc + 1;
      start = 1'b1;
      rel = 0;
      do begin @(posedge clk); #1; rel++; end while (!done && rel < 100);
      chk("hold_done1", done, 1'b1);
      @(posedge clk); #1;
      chk("hold_idle_gap", busy, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_restart_busy", busy, 1'b1);
      chk("hold_restart_pc", pc, 0);
      rel = 0;
      while (!done && rel < 100) begin @(posedge clk); #1; rel++; end
      chk("hold_done2", done, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      chk("hold_drain", trace_q.size(), 0);
      $display("run hold_start: second done seen after %0d cycles", rel);

      // Randomized programs with start noise while busy
      for (int r = 0; r < 20; r++) begin
         int tries;
         tries = 0;
         do begin
            for (int i = 0; i < 8; i++) begin
               int sel;
               logic [2:0] op;
               sel = $urandom_range(0, 9);
               case (sel)
                  0, 1: op = 3'd5;
                  2: op = 3'd1;
                  3: op = 3'd2;
                  4: op = 3'd3;
                  5: op = 3'd4;
                  6: op = 3'd0;
                  7: op = 3'd6;
                  default: op = 3'd7;
               endcase
               prog[i] = mkw(op, 3'($urandom), 3'($urandom), 3'($urandom), $urandom);
            end
            n = model_run(0, 1'b0, '0, 1'b0);
            tries++;
         end while (n < 0 && tries < 50);
         if (n < 0) prog[0] = mkw(3'd7, 0, 0, 0, 0);
         run_prog($sformatf("rand%0d", r), 1'b1, 1'b0, '0);
      end
      for (int i = 0; i < 8; i++) chk($sformatf("rf%0d_final", i), rf[i], mreg[i]);

      // Reset asserted during WRITE of an LDI aborts without writing
      fill_halt();
      prog[0] = mkw(3'd5, 3'd1, 0, 0, ~mreg[1]);
      n = model_run(4, 1'b0, '0, 1'b1);
      strict = 1'b0;
      t0 = cyc + 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_we_in_write", we, 1'b1);
      reset = 1'b0;
      #1;
      chk("abort_we", we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pc", pc, 0);
      chk("abort_alu_op", alu_op, 0);
      chk("abort_a0", a0, 0);
      chk("abort_a1", a1, 0);
      chk("abort_aw", aw, 0);
      chk("abort_wd", wd, 0);
      @(posedge clk); #1;
      chk("abort_rf1_unchanged", rf[1], mreg[1]);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle_busy", busy, 0);
      chk("abort_drain", trace_q.size(), 0);
      strict = 1'b1;
      $display("run reset_abort: write suppressed, rf1=%0h", rf[1]);
      repeat (2) begin @(posedge clk); #1; end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer driving the register-file/ALU datapath. On `start` it fetches instruction words from a combinational program memory, decodes them, and drives regfile read addresses, ALU opcode and regfile write-back. It runs until a HALT opcode, then pulses `done`. It replaces the free-running counter-plus-decode control with a handshaked FSM.

## Interface
- `N`, 32, data width (regfile data, ALU operands, immediate)
- `AW`, 3, regfile address width
- `PW`, 3, program-counter width (2^PW instruction words)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin execution at address 0; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after HALT retires
- `pc`  out  PW  current program counter, also the program-memory address
- `instr`  in  12+N  program word: [op 3 | rd 3 | ra 3 | rb 3 | imm N]
- `a0`, `a1`  out  AW  regfile read addresses
- `q0`, `q1`  in  N  regfile read data (combinational from `a0`/`a1`)
- `alu_op`  out  3  ALU opcode
- `alu_y`  in  N  ALU result (combinational)
- `aw`  out  AW  regfile write address
- `wd`  out  N  regfile write data
- `we`  out  1  regfile write enable

## Operation
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LDI (rd ← imm), 110 JMP (pc ← imm[PW-1:0]), 111 HALT.
- States: IDLE, FETCH, DECODE, EXEC, WRITE, DONE.
- IDLE: `start`=1 → `pc`←0, go to FETCH. `start` in any other state is ignored.
- FETCH: `ir`←`instr` (addressed by `pc`) → DECODE.
- DECODE: `a0`=ir.ra, `a1`=ir.rb, `alu_op`=ir.op.
  - ALU ops and LDI → EXEC.
  - NOP → `pc`←`pc`+1, FETCH.
  - JMP → `pc`←imm[PW-1:0], FETCH.
  - HALT → DONE; `pc` holds.
- EXEC: `result`←`alu_y` for ALU ops, `result`←imm for LDI. `a0`/`a1`/`alu_op` are held from DECODE → WRITE.
- WRITE: `we`=1, `aw`=ir.rd, `wd`=`result`; `pc`←`pc`+1 → FETCH.
- DONE: `done`=1 for this single cycle → IDLE.
- `pc` increments modulo 2^PW: 2^PW−1 wraps to 0 with no error and no stop.
- Register 0 is not special; writes to rd=0 occur normally.
- Outputs are Moore-decoded from state plus registers `ir`, `result` and `pc`. No combinational path from `q0`/`q1`/`alu_y` to any output.
- Outside DECODE/EXEC, `alu_op`=000 and `a0`/`a1` hold their last value. `we`=0 outside WRITE.

## Timing
- Reset (`reset`=0, asynchronous) forces: state IDLE, `pc`=0, `ir`=0, `result`=0, `busy`=0, `done`=0, `we`=0, `a0`=`a1`=`aw`=0, `wd`=0, `alu_op`=0.
- Reset asserted mid-instruction aborts immediately. A WRITE in progress produces no write.
- Start latency: `start` high at edge k puts FETCH in cycle k+1; `busy` rises in cycle k+1.
- Cycle counts:
  - ALU op or LDI: 4 cycles (FETCH, DECODE, EXEC, WRITE).
  - NOP or JMP: 2 cycles.
  - HALT: 2 cycles plus 1 DONE cycle; `busy` is high during DONE and low the cycle after.
- `we` is high exactly one cycle per retired ALU/LDI instruction.
- `q0`/`q1`/`alu_y` are sampled at the end of EXEC and must be valid within one cycle.
- `start` held high through DONE restarts execution at pc=0 on the cycle after DONE, from IDLE.

## Structure
- Shared package `seq_pkg`:
  - `opcode_t` enum (3 bits) and `state_t` enum.
  - localparams for field positions: OP_MSB = 11+N, RD/RA/RB offsets, IMM_LSB = 0.
  - Instruction-width function IW = 12+N.
- One sub-module, `pc_counter`: PW-bit register with clear, load and increment, same clock and reset. Priority is clear > load > inc.
- FSM and datapath registers (`ir`, `result`) live in `instr_sequencer`.

## Test plan
- Reset mid-run: assert `reset`=0 during WRITE → `we`=0 immediately, regfile unchanged, all outputs at reset values, `busy`=0.
- LDI/ADD/HALT: program [LDI r1,5; LDI r2,7; ADD r3←r1,r2; HALT] with model regfile+ALU → writes (1,5), (2,7), (3,12). `done` pulses 15 cycles after `start` (4+4+4+2, then DONE); `busy` covers exactly those 15 cycles.
- NOP/JMP: JMP 3 at addr 0, NOP at 3, HALT at 4 → `pc` sequence 0,3,4. No `we` pulses. `done` after 6 active cycles.
- Wrap-around: program words 0–6 are NOP, word 7 is NOP, word 0 JMP to 5, word 5 HALT... Concretely: address 7 = NOP, address 0 = HALT, started with a JMP 7 placed at address 0 on the first pass → `pc` goes 7→0 and HALT is reached. Check `pc` wraps 7→0 with no stall.
- `start` ignored while busy: pulse `start` during EXEC → no restart, `pc` unaffected. Hold `start` high through DONE → new run begins from pc=0 after one IDLE cycle.
- SUB/AND/OR: ra=r1=0xF0, rb=r2=0x3C → r4=0xB4 (SUB), r5=0x30 (AND), r6=0xFC (OR). `alu_op` is 010/011/100 during the matching DECODE/EXEC cycles.
